// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer line fetcher.
// State encoding, frame geometry defaults and bus constants.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } fb_state_t;

  localparam int H_PIXELS_DEF = 640;
  localparam int V_LINES_DEF  = 480;
  localparam int FRAME_PIXELS = H_PIXELS_DEF * V_LINES_DEF;

  localparam logic [1:0] BE_ALL = 2'b11;

  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Synchronous first-word-fall-through pixel FIFO.
// Head is visible on dout whenever the FIFO is non-empty.
module fb_pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush &
                   ((cnt != CW'(DEPTH)) | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; only written on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; flush empties in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fb_line_fetcher.sv
// Read-side framebuffer master: sequential pixel reads into a FIFO.
// One outstanding bus read; restarts never abort a bus transaction.
module fb_line_fetcher
  import fb_pkg::*;
#(
  parameter int                ADDR_W     = 27,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] FB_BASE    = '0,
  parameter int                H_PIXELS   = H_PIXELS_DEF,
  parameter int                V_LINES    = V_LINES_DEF,
  parameter int                FIFO_DEPTH = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              frame_start,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  output logic              busy,
  output logic [ADDR_W-1:0] bridge_memory_address,
  output logic [1:0]        bridge_memory_byte_enable,
  output logic              bridge_memory_read,
  output logic              bridge_memory_write,
  output logic [DATA_W-1:0] bridge_memory_write_data,
  input  logic              bridge_memory_acknowledge,
  input  logic [DATA_W-1:0] bridge_memory_read_data
);

  localparam int FRAME = frame_pixels(H_PIXELS, V_LINES);
  localparam int IDX_W = $clog2(FRAME+1);
  localparam int CW    = $clog2(FIFO_DEPTH+1);

  fb_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              pend_q, pend_d;
  logic              und_q, und_d;
  logic              push;
  logic              flush;
  logic              pop;
  logic              room;
  logic              ack_hit;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;

  assign ack_hit = bridge_memory_acknowledge & read_q;
  assign idx_inc = idx_q + 1'b1;
  assign room    = ({1'b0, fifo_count} + 1'b1) <=
                   (CW+1)'(FIFO_DEPTH);
  assign pop     = pix_ready & ~fifo_empty;

  // Next-state, bus request and restart bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    read_d  = read_q;
    pend_d  = pend_q;
    push    = 1'b0;
    flush   = 1'b0;
    und_d   = und_q | (pix_ready & fifo_empty);
    if (frame_start) begin
      und_d = 1'b0;
    end
    unique case (state_q)
      IDLE, DONE: begin
        if (frame_start) begin
          flush   = 1'b1;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (frame_start) begin
          flush = 1'b1;
          idx_d = '0;
        end else if (room) begin
          read_d  = 1'b1;
          addr_d  = FB_BASE + (ADDR_W'(idx_q) << 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack_hit) begin
          read_d = 1'b0;
          pend_d = 1'b0;
          if (pend_q | frame_start) begin
            flush   = 1'b1;
            idx_d   = '0;
            state_d = ISSUE;
          end else begin
            push    = 1'b1;
            idx_d   = idx_inc;
            state_d = (idx_inc == IDX_W'(FRAME)) ? DONE : ISSUE;
          end
        end else if (frame_start) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
      end
    endcase
  end

  // State, pixel index and bus registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      pend_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      pend_q  <= pend_d;
      und_q   <= und_d;
    end
  end

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bridge_memory_read_data),
    .dout  (pix_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign pix_valid                 = ~fifo_empty;
  assign underflow                 = und_q;
  assign busy                      = (state_q == ISSUE) |
                                     (state_q == WAIT);
  assign bridge_memory_address     = addr_q;
  assign bridge_memory_read        = read_q;
  assign bridge_memory_byte_enable = read_q ? BE_ALL : 2'b00;
  assign bridge_memory_write       = 1'b0;
  assign bridge_memory_write_data  = '0;

endmodule

// File: tb/tb_fb_line_fetcher.sv
// Directed bench for fb_line_fetcher with a latency-programmable bridge.
// Expected addresses and pixels are queued up front and popped on output.
module tb_fb_line_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_ready = 1'b0;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        underflow;
  logic        busy;
  logic [26:0] addr;
  logic [1:0]  be;
  logic        rd;
  logic        wr;
  logic [15:0] wdata;
  logic        ack = 1'b0;
  logic [15:0] rdata = '0;

  int total = 0;
  int bad = 0;
  int lat = 0;
  int wcnt = 0;
  int nreads = 0;
  int hi_cnt = 0;
  int base = 0;
  bit mon_en = 1'b1;
  logic rd_prev = 1'b0;
  logic [26:0] hold_addr = '0;

  int exp_addr[$];
  int exp_pix[$];

  fb_line_fetcher #(
    .ADDR_W     (27),
    .DATA_W     (16),
    .FB_BASE    (27'h0),
    .H_PIXELS   (4),
    .V_LINES    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_clk                   (clk),
    .reset_reset_n             (rst_n),
    .frame_start               (frame_start),
    .pix_ready                 (pix_ready),
    .pix_valid                 (pix_valid),
    .pix_data                  (pix_data),
    .underflow                 (underflow),
    .busy                      (busy),
    .bridge_memory_address     (addr),
    .bridge_memory_byte_enable (be),
    .bridge_memory_read        (rd),
    .bridge_memory_write       (wr),
    .bridge_memory_write_data  (wdata),
    .bridge_memory_acknowledge (ack),
    .bridge_memory_read_data   (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bridge model: acks after lat extra read-high cycles, echoes addr.
  always @(negedge clk) begin
    if (!rst_n || !rd) begin
      ack = 1'b0;
      wcnt = 0;
    end else if (ack) begin
      ack = 1'b0;
    end else if (wcnt >= lat) begin
      ack = 1'b1;
      rdata = addr[15:0];
    end else begin
      wcnt++;
    end
  end

  // Bus monitor: request address order, stability and hold length.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd && !rd_prev) begin
        nreads++;
        hold_addr = addr;
        hi_cnt = 0;
        total++;
        assert (exp_addr.size() != 0) else begin
          bad++;
          $error("FAIL extra_read observed addr=%0h expected none", addr);
        end
        if (exp_addr.size() != 0) begin
          chk("rd_addr", 32'(addr), 32'(exp_addr.pop_front()));
        end
      end
      if (rd) begin
        hi_cnt++;
        chk("addr_hold", 32'(addr), 32'(hold_addr));
        chk("be_rd", 32'(be), 32'h3);
      end else begin
        chk("be_idle", 32'(be), 32'h0);
        if (rd_prev) begin
          chk("rd_len", 32'(hi_cnt), 32'(lat + 1));
        end
      end
      rd_prev = rd;
    end
  end

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic queue_frame();
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(2 * i);
      exp_pix.push_back(2 * i);
    end
  endtask

  task automatic drain(input int n, input int budget, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      if (pix_valid) begin
        pix_ready = 1'b1;
        chk(tag, 32'(pix_data), 32'(exp_pix.pop_front()));
        got++;
      end else begin
        pix_ready = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    pix_ready = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic wait_rd(input logic v, input int budget, input string tag);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (rd !== v && c < budget);
    chk(tag, 32'(rd), 32'(v));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (busy !== 1'b0 && c < budget);
    chk(tag, 32'(busy), 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_data", 32'(pix_data), 0);
    chk("rst_und", 32'(underflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_be", 32'(be), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rd", 32'(rd), 0);

    // 1: zero-wait frame.
    lat = 0;
    base = nreads;
    queue_frame();
    pulse_fs();
    chk("t1_busy", 32'(busy), 1);
    drain(8, 200, "t1_pix");
    wait_idle(50, "t1_idle");
    chk("t1_reads", 32'(nreads - base), 8);
    chk("t1_addrq", 32'(exp_addr.size()), 0);
    chk("t1_empty", 32'(pix_valid), 0);

    // 2: five-cycle bridge latency.
    lat = 5;
    base = nreads;
    queue_frame();
    pulse_fs();
    drain(8, 400, "t2_pix");
    wait_idle(50, "t2_idle");
    chk("t2_reads", 32'(nreads - base), 8);

    // 3: consumer stalled, FIFO of four.
    lat = 0;
    base = nreads;
    queue_frame();
    pulse_fs();
    repeat (40) @(negedge clk);
    chk("t3_reads4", 32'(nreads - base), 4);
    chk("t3_rd_low", 32'(rd), 0);
    chk("t3_busy", 32'(busy), 1);
    chk("t3_valid", 32'(pix_valid), 1);
    chk("t3_head", 32'(pix_data), 32'(exp_pix.pop_front()));
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_reads5", 32'(nreads - base), 5);
    chk("t3_rd_low2", 32'(rd), 0);
    drain(7, 200, "t3_pix");
    wait_idle(50, "t3_idle");
    chk("t3_reads", 32'(nreads - base), 8);

    // 4: restart while a read is in flight.
    lat = 3;
    base = nreads;
    exp_addr.push_back(0);
    queue_frame();
    pulse_fs();
    wait_rd(1'b1, 20, "t4_rise");
    pulse_fs();
    chk("t4_rd_held", 32'(rd), 1);
    wait_rd(1'b0, 20, "t4_fall");
    chk("t4_discard", 32'(pix_valid), 0);
    drain(8, 400, "t4_pix");
    wait_idle(50, "t4_idle");
    chk("t4_reads", 32'(nreads - base), 9);
    chk("t4_addrq", 32'(exp_addr.size()), 0);

    // 5: underflow is sticky until frame_start.
    lat = 0;
    chk("t5_und0", 32'(underflow), 0);
    @(negedge clk);
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    chk("t5_und1", 32'(underflow), 1);
    chk("t5_valid", 32'(pix_valid), 0);
    chk("t5_data", 32'(pix_data), 0);
    repeat (3) @(negedge clk);
    chk("t5_sticky", 32'(underflow), 1);
    queue_frame();
    pulse_fs();
    chk("t5_clear", 32'(underflow), 0);
    drain(8, 200, "t5_pix");
    wait_idle(50, "t5_idle");

    // 6: asynchronous reset mid-read.
    lat = 5;
    exp_addr.delete();
    exp_pix.delete();
    exp_addr.push_back(0);
    pulse_fs();
    wait_rd(1'b1, 20, "t6_rise");
    mon_en = 1'b0;
    base = nreads;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd", 32'(rd), 0);
    chk("t6_be", 32'(be), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_addr", 32'(addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_rd", 32'(rd), 0);
    chk("t6_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
